// File: rtl/bt_uart_tx.sv
// rtl/bt_uart_tx.sv - UART transmitter (8 data bits, 1 stop bit) with a small TX FIFO
//
// Purpose:
//   Serialises bytes queued by control logic onto the HC-06 RXD line.
//   Frames are start(0), 8 data bits LSB first, stop(1). Consecutive queued
//   bytes go out back to back with no idle gap between stop and start.
//   Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
//   after data bit 7 (11-bit frames). Undefined by default (8N1).
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   BAUD        line rate; CLK_HZ/BAUD clocks per bit
//   FIFO_DEPTH  TX FIFO entries, power of two, >= 2
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high; aborts any frame, empties the FIFO
//   wr_en     push wr_data into the FIFO this cycle
//   wr_data   byte to queue
//   full      FIFO holds FIFO_DEPTH bytes (registered)
//   empty     FIFO holds 0 bytes (registered)
//   level     FIFO occupancy 0..FIFO_DEPTH (registered)
//   overflow  one-cycle pulse: write dropped because the FIFO was full
//   busy      frame in progress (state != IDLE)
//   tx        serial output, idle high, registered

module bt_uart_tx #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          cnt_last;

  assign head     = mem[rd_ptr];
  assign cnt_last = (cnt == CW'(BAUD_DIV - 1));
  // full is the registered flag, so a write while full is dropped even if
  // the FSM pops in the same cycle.
  assign push     = wr_en && !full;
  // Pop on leaving IDLE, or on the last stop-bit clock to chain frames.
  assign pop      = !empty && ((state == S_IDLE) || (state == S_STOP && cnt_last));

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + LW'(1);
    else if (pop && !push)
      level_nxt = level - LW'(1);
  end

  // FIFO storage carries no reset; stale entries are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      overflow <= wr_en && full;
      level    <= level_nxt;
      full     <= (level_nxt == LW'(FIFO_DEPTH));
      empty    <= (level_nxt == '0);
    end
  end

  // tx is registered from the current state, so the line lags the state by
  // one clock; every bit still lasts exactly BAUD_DIV clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      busy    <= 1'b0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= head;
`ifdef UART_TX_PARITY_EN
            par   <= ^head;
`endif
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_START;
          end
        end

        S_START: begin
          tx <= 1'b0;
          if (cnt_last) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DATA: begin
          tx <= shift[0];
          if (cnt_last) begin
            cnt   <= '0;
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          tx <= par;
          if (cnt_last) begin
            cnt   <= '0;
            state <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        S_STOP: begin
          tx <= 1'b1;
          if (cnt_last) begin
            cnt <= '0;
            if (pop) begin
              shift <= head;
`ifdef UART_TX_PARITY_EN
              par   <= ^head;
`endif
              state <= S_START;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bt_uart_tx.sv
// tb/tb_bt_uart_tx.sv - directed self-checking bench for bt_uart_tx
//
// Purpose:
//   Drives bt_uart_tx with a reduced baud divider (4 clocks per bit) and
//   checks reset state, frame shape, back-to-back frames, FIFO full/overflow
//   and asynchronous reset abort. Honours UART_TX_PARITY_EN.
//
// Ports: none (top-level bench).

module tb_bt_uart_tx;

  localparam int B  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * B;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       overflow;
  logic       busy;
  logic       tx;

  int n_checks = 0;
  int n_fail   = 0;

  bt_uart_tx #(.CLK_HZ(40), .BAUD(10), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .busy     (busy),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after tx fell for the start bit; returns at the first
  // clock of the stop bit.
  task automatic check_frame(input logic [7:0] d);
    logic [10:0] fr;
    fr = '1;
    fr[0]   = 1'b0;
    fr[8:1] = d;
`ifdef UART_TX_PARITY_EN
    fr[9]   = ^d;
`endif
    check("frame_start", tx, 1'b0);
    for (int k = 1; k < NB; k++) begin
      repeat (B - 1) tick();
      check("frame_bit_end", tx, fr[k-1]);
      tick();
      check("frame_bit", tx, fr[k]);
    end
  endtask

  int lows;

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    #2;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_level", level, 4'd0);
    check("rst_overflow", overflow, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();

    // Single byte 0x41 into an idle block.
    wr_en = 1'b1; wr_data = 8'h41;
    tick();
    wr_en = 1'b0;
    check("t1_empty_after_push", empty, 1'b0);
    check("t1_level_after_push", level, 4'd1);
    check("t1_tx_still_idle", tx, 1'b1);
    tick();
    check("t1_busy_after_pop", busy, 1'b1);
    check("t1_empty_after_pop", empty, 1'b1);
    check("t1_tx_before_fall", tx, 1'b1);
    tick();
    check_frame(8'h41);
    tick(); tick();
    check("t1_busy_last", busy, 1'b1);
    tick();
    check("t1_busy_done", busy, 1'b0);
    check("t1_tx_idle", tx, 1'b1);
    repeat (B) tick();

    // Three bytes on consecutive clocks: frames must abut.
    wr_en = 1'b1; wr_data = 8'h41; tick();
    wr_data = 8'h42; tick();
    wr_data = 8'h55; tick();
    wr_en = 1'b0;
    check("t2_level", level, 4'd2);
    check_frame(8'h41);
    repeat (B) tick();
    check_frame(8'h42);
    repeat (B) tick();
    check_frame(8'h55);
    tick(); tick();
    check("t2_busy_last", busy, 1'b1);
    tick();
    check("t2_busy_done", busy, 1'b0);
    check("t2_empty", empty, 1'b1);
    repeat (B) tick();

    // Ten writes: first popped, eight fill the FIFO, tenth overflows.
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'h10 + 8'(i);
      tick();
      if (i == 8) begin
        check("t3_full", full, 1'b1);
        check("t3_level_full", level, 4'd8);
        check("t3_no_overflow_yet", overflow, 1'b0);
      end
      if (i == 9) begin
        check("t3_overflow", overflow, 1'b1);
        check("t3_level_held", level, 4'd8);
      end
    end
    wr_en = 1'b0;
    tick();
    check("t3_overflow_pulse", overflow, 1'b0);
    check("t3_full_after", full, 1'b1);
    repeat (FL - 8) tick();
    for (int i = 1; i < 9; i++) begin
      check_frame(8'h10 + 8'(i));
      if (i < 8) repeat (B) tick();
    end
    tick(); tick(); tick();
    check("t3_busy_done", busy, 1'b0);
    check("t3_empty", empty, 1'b1);
    lows = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("t3_dropped_never_sent", lows, 0);

    // Reset at data bit 4 with three bytes queued.
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'hA0 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("t4_level_queued", level, 4'd3);
    repeat (20 - 2 + 2) tick();
    check("t4_busy_mid", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t4_async_tx", tx, 1'b1);
    check("t4_async_busy", busy, 1'b0);
    check("t4_async_empty", empty, 1'b1);
    check("t4_async_level", level, 4'd0);
    tick();
    tick();
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("t4_no_frames", lows, 0);
    check("t4_empty_after", empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
